spi_adc_scanner: RTL and testbench

- Parametrised multi-channel SPI ADC controller. It supersedes the single-shot, fixed 10-bit SPI ADC reader.
- Generates SCLK internally from the system clock and scans a masked set of ADC channels, once or continuously.
- Stores one result per channel in a register bank that the CPU-side logic reads asynchronously by channel index.
- Sits between the CPU peripheral bus and an external MCP300x-style ADC.

---
 rtl/spi_adc_scanner.sv | 185 ++++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_adc_scanner : masked multi-channel SPI (mode 0) ADC scanner, result bank
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_adc_scanner #(
  parameter int DATA_W  = 10,
  parameter int NUM_CH  = 8,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic              done,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int FRAME  = 3 + CH_W + DATA_W;
  localparam int HOLD_N = CS_IDLE * 2 * CLK_DIV;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W  = $clog2(FRAME + 1);
  localparam int HLD_W  = $clog2(HOLD_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_NEXT} state_t;

  state_t              state_q;
  logic                busy_q, done_q, cs_q, sclk_q, mosi_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [CH_W-1:0]     ch_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [HLD_W-1:0]    hold_q;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   bank_q [NUM_CH];
  logic [NUM_CH-1:0]   valid_q;

  logic                low_found_d, nxt_found_d, cmd_bit_d;
  logic [CH_W-1:0]     low_ch_d, nxt_ch_d, ch_shift_d;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    low_found_d = 1'b0;
    low_ch_d    = '0;
    nxt_found_d = 1'b0;
    nxt_ch_d    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_found_d = 1'b1;
        low_ch_d    = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found_d = 1'b1;
        nxt_ch_d    = CH_W'(i);
      end
    end
  end

  // Command bit k (k = rises so far): 1 = SGL, 2..1+CH_W = channel MSB first.
  always_comb begin
    ch_shift_d = ch_q << (bit_q - BIT_W'(2));
    cmd_bit_d  = 1'b0;
    if (bit_q == BIT_W'(1)) begin
      cmd_bit_d = 1'b1;
    end else if ((bit_q >= BIT_W'(2)) && (bit_q < BIT_W'(2 + CH_W))) begin
      cmd_bit_d = ch_shift_d[CH_W-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      mask_q  <= '0;
      ch_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      sh_q    <= '0;
      valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && low_found_d) begin
            mask_q  <= ch_mask;
            ch_q    <= low_ch_d;
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            mosi_q  <= 1'b1;
            div_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            bit_q   <= BIT_W'(1);
            state_q <= S_XFER;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_XFER: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              bit_q  <= bit_q + 1'b1;
              if (bit_q >= BIT_W'(3 + CH_W)) sh_q <= (sh_q << 1) | DATA_W'(MISO);
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_W'(FRAME)) begin
                bank_q[ch_q]  <= sh_q;
                valid_q[ch_q] <= 1'b1;
                cs_q          <= 1'b1;
                mosi_q        <= 1'b0;
                hold_q        <= '0;
                state_q       <= S_HOLD;
              end else begin
                mosi_q <= cmd_bit_d;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_q == HLD_LAST) state_q <= S_NEXT;
          else hold_q <= hold_q + 1'b1;
        end
        S_NEXT: begin
          if (nxt_found_d) begin
            ch_q    <= nxt_ch_d;
            cs_q    <= 1'b0;
            mosi_q  <= 1'b1;
            div_q   <= '0;
            state_q <= S_SETUP;
          end else begin
            done_q <= 1'b1;
            if (cont && low_found_d) begin
              mask_q  <= ch_mask;
              ch_q    <= low_ch_d;
              cs_q    <= 1'b0;
              mosi_q  <= 1'b1;
              div_q   <= '0;
              state_q <= S_SETUP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign CS       = cs_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign rd_data  = (int'(rd_ch) < NUM_CH) ? bank_q[rd_ch] : '0;
  assign rd_valid = (int'(rd_ch) < NUM_CH) ? valid_q[rd_ch] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_adc_scanner : directed bench with an MCP300x-style ADC model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spi_adc_scanner;
  logic       CLK;
  logic       RST;
  logic       start, cont, busy, done, rd_valid, SCLK, CS, MOSI, MISO;
  logic [7:0] ch_mask;
  logic [2:0] rd_ch;
  logic [9:0] rd_data;

  logic        start_b, busy_b, done_b, rd_valid_b, SCLK_b, CS_b, MOSI_b, MISO_b;
  logic [3:0]  ch_mask_b;
  logic [1:0]  rd_ch_b;
  logic [11:0] rd_data_b;

  spi_adc_scanner dut (
    .CLK(CLK), .RST(RST), .start(start), .cont(cont), .ch_mask(ch_mask),
    .busy(busy), .done(done), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
  );

  spi_adc_scanner #(.DATA_W(12), .NUM_CH(4), .CLK_DIV(1)) dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .cont(1'b0), .ch_mask(ch_mask_b),
    .busy(busy_b), .done(done_b), .rd_ch(rd_ch_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .SCLK(SCLK_b), .CS(CS_b), .MOSI(MOSI_b), .MISO(MISO_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ADC model for the default instance: counts rises, decodes the channel
  // from the command bits and shifts the channel's value out MSB first.
  logic [9:0] adc_val [8];
  logic [9:0] mv;
  int         rcnt = 0;
  logic [7:0] cmd = '0;
  always @(negedge CS) begin
    rcnt = 0;
    cmd  = '0;
  end
  always @(posedge SCLK) if (!CS) begin
    rcnt = rcnt + 1;
    if (rcnt <= 5) cmd = {cmd[6:0], MOSI};
  end
  always_comb begin
    mv   = adc_val[cmd[2:0]];
    MISO = 1'b0;
    if (rcnt >= 6 && rcnt < 16) MISO = mv[4'(15 - rcnt)];
  end

  int         lowcnt = 0, last_low = 0, highcnt = 0, last_gap = 0;
  int         frames = 0, done_cnt = 0, last_rises = 0;
  logic [4:0] first_cmd = '0;
  int         ch_log[$];
  always @(posedge CLK) begin
    if (done) done_cnt++;
    if (!CS) begin
      if (lowcnt == 0 && frames > 0) last_gap = highcnt;
      lowcnt++;
    end else begin
      if (lowcnt != 0) begin
        last_low   = lowcnt;
        last_rises = rcnt;
        if (frames == 0) first_cmd = cmd[4:0];
        ch_log.push_back(int'(cmd[2:0]));
        frames++;
        lowcnt  = 0;
        highcnt = 0;
      end
      highcnt++;
    end
  end

  // Model for the 12-bit / 4-channel / CLK_DIV=1 instance.
  logic [11:0] adc_val_b;
  int          rcnt_b = 0, lowcnt_b = 0, last_low_b = 0, last_rises_b = 0;
  logic [3:0]  cmd_b = '0, last_cmd_b = '0;
  always @(negedge CS_b) begin
    rcnt_b = 0;
    cmd_b  = '0;
  end
  always @(posedge SCLK_b) if (!CS_b) begin
    rcnt_b = rcnt_b + 1;
    if (rcnt_b <= 4) cmd_b = {cmd_b[2:0], MOSI_b};
  end
  always_comb begin
    MISO_b = 1'b0;
    if (rcnt_b >= 5 && rcnt_b < 17) MISO_b = adc_val_b[4'(16 - rcnt_b)];
  end
  always @(posedge CLK) begin
    if (!CS_b) lowcnt_b++;
    else if (lowcnt_b != 0) begin
      last_low_b   = lowcnt_b;
      last_rises_b = rcnt_b;
      last_cmd_b   = cmd_b;
      lowcnt_b     = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    frames   = 0;
    done_cnt = 0;
    last_gap = 0;
    ch_log.delete();
  endtask

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_ch(input logic [2:0] c, input logic [9:0] ed, input logic ev, input string nm);
    rd_ch = c;
    #1;
    chk({nm, "_data"}, 32'(rd_data), 32'(ed));
    chk({nm, "_valid"}, 32'(rd_valid), 32'(ev));
  endtask

  // Single non-continuous scan; optionally fires a second start mid-scan.
  task automatic do_scan(input logic [7:0] m, input bit interfere);
    bit ok;
    clr_mon();
    ch_mask = m;
    pulse_start();
    if (interfere) begin
      repeat (30) @(negedge CLK);
      ch_mask = 8'h02;
      pulse_start();
    end
    wait_done(4000, ok);
    chk("done_seen", 32'(ok), 1);
    chk("busy_falls_with_done", 32'(busy), 0);
    @(negedge CLK);
    chk("done_one_cycle", 32'(done), 0);
    chk("done_count", done_cnt, 1);
  endtask

  typedef struct {
    logic [7:0] mask;
    logic [9:0] d;
    logic [2:0] rch;
    logic [9:0] exp_data;
    logic       exp_valid;
    int         exp_frames;
    logic [4:0] exp_cmd;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{8'h04, 10'h2A5, 3'd2, 10'h2A5, 1'b1, 1, 5'b11010};
    vecs[1] = '{8'h30, 10'h155, 3'd5, 10'h155, 1'b1, 2, 5'b11100};
    vecs[2] = '{8'h0A, 10'h0F0, 3'd3, 10'h0F0, 1'b1, 2, 5'b11001};
    vecs[3] = '{8'h40, 10'h3C3, 3'd6, 10'h3C3, 1'b1, 1, 5'b11110};
    vecs[4] = '{8'h01, 10'h000, 3'd7, 10'h000, 1'b0, 1, 5'b11000};
    vecs[5] = '{8'hFF, 10'h1FF, 3'd7, 10'h1FF, 1'b1, 8, 5'b11000};

    RST = 1'b1; start = 1'b0; cont = 1'b0; ch_mask = '0; rd_ch = '0;
    start_b = 1'b0; ch_mask_b = '0; rd_ch_b = '0; adc_val_b = '0;
    for (int i = 0; i < 8; i++) adc_val[i] = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_cs", 32'(CS), 1);
    chk("rst_sclk", 32'(SCLK), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    for (int i = 0; i < 8; i++) read_ch(3'(i), 10'h000, 1'b0, "rst_bank");
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("idle_cs", 32'(CS), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_frames", frames, 0);

    // Table-driven single scans
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) adc_val[i] = vecs[v].d;
      do_scan(vecs[v].mask, 1'b0);
      chk("tbl_frames", frames, vecs[v].exp_frames);
      chk("tbl_cmd", 32'(first_cmd), 32'(vecs[v].exp_cmd));
      chk("tbl_cs_low_clks", last_low, 128);
      chk("tbl_rises", last_rises, 16);
      read_ch(vecs[v].rch, vecs[v].exp_data, vecs[v].exp_valid, "tbl_rd");
    end

    // Multi-channel order
    adc_val[0] = 10'h001; adc_val[7] = 10'h3FF;
    do_scan(8'h81, 1'b0);
    chk("order_frames", ch_log.size(), 2);
    if (ch_log.size() == 2) begin
      chk("order_first", ch_log[0], 0);
      chk("order_second", ch_log[1], 7);
    end
    chk("order_gap_ge16", 32'(last_gap >= 16), 1);
    read_ch(3'd0, 10'h001, 1'b1, "order_ch0");
    read_ch(3'd7, 10'h3FF, 1'b1, "order_ch7");

    // Continuous scanning
    adc_val[0] = 10'h111; adc_val[1] = 10'h222;
    clr_mon();
    cont = 1'b1; ch_mask = 8'h03;
    pulse_start();
    wait_done(2000, ok);
    chk("cont_done1", 32'(ok), 1);
    chk("cont_frames1", frames, 2);
    chk("cont_busy_kept", 32'(busy), 1);
    read_ch(3'd1, 10'h222, 1'b1, "cont_scan1_ch1");
    adc_val[0] = 10'h0AA; adc_val[1] = 10'h155;
    frames = 0;
    wait_done(2000, ok);
    chk("cont_done2", 32'(ok), 1);
    chk("cont_frames2", frames, 2);
    chk("cont_busy_kept2", 32'(busy), 1);
    read_ch(3'd0, 10'h0AA, 1'b1, "cont_ch0");
    read_ch(3'd1, 10'h155, 1'b1, "cont_ch1");
    frames = 0;
    repeat (40) @(negedge CLK);
    cont = 1'b0;
    wait_done(2000, ok);
    chk("cont_stop_done", 32'(ok), 1);
    chk("cont_stop_frames", frames, 2);
    chk("cont_stop_busy", 32'(busy), 0);
    repeat (200) @(negedge CLK);
    chk("cont_stays_idle", frames, 2);
    chk("cont_idle_cs", 32'(CS), 1);

    // Ignored requests
    clr_mon();
    ch_mask = 8'h00;
    pulse_start();
    repeat (5) @(negedge CLK);
    chk("zero_mask_busy", 32'(busy), 0);
    chk("zero_mask_cs", 32'(CS), 1);
    adc_val[0] = 10'h0F1; adc_val[7] = 10'h30E;
    do_scan(8'h81, 1'b1);
    chk("busy_start_frames", ch_log.size(), 2);
    if (ch_log.size() == 2) begin
      chk("busy_start_first", ch_log[0], 0);
      chk("busy_start_second", ch_log[1], 7);
    end
    chk("busy_start_cs_low", last_low, 128);
    read_ch(3'd0, 10'h0F1, 1'b1, "busy_start_ch0");
    read_ch(3'd7, 10'h30E, 1'b1, "busy_start_ch7");
    read_ch(3'd1, 10'h155, 1'b1, "busy_start_ch1_untouched");

    // Abort during data phase
    adc_val[3] = 10'h123; adc_val[2] = 10'h2A5;
    clr_mon();
    ch_mask = 8'h08;
    pulse_start();
    repeat (100) @(negedge CLK);
    chk("abort_in_frame", 32'(CS), 0);
    RST = 1'b1;
    #1;
    chk("abort_cs", 32'(CS), 1);
    chk("abort_sclk", 32'(SCLK), 0);
    chk("abort_busy", 32'(busy), 0);
    read_ch(3'd2, 10'h000, 1'b0, "abort_cleared");
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    do_scan(8'h04, 1'b0);
    read_ch(3'd2, 10'h2A5, 1'b1, "restart_ch2");
    read_ch(3'd3, 10'h000, 1'b0, "restart_ch3_invalid");
    read_ch(3'd0, 10'h000, 1'b0, "restart_ch0_invalid");

    // 12-bit, 4-channel, CLK_DIV=1 instance
    adc_val_b = 12'hA5C;
    ch_mask_b = 4'h4;
    @(negedge CLK) start_b = 1'b1;
    @(negedge CLK) start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("var_done", 32'(ok), 1);
    chk("var_busy", 32'(busy_b), 0);
    chk("var_rises", last_rises_b, 17);
    chk("var_cs_low_clks", last_low_b, 34);
    chk("var_cmd", 32'(last_cmd_b), 32'(4'b1110));
    rd_ch_b = 2'd2;
    #1;
    chk("var_rd_data", 32'(rd_data_b), 32'(12'hA5C));
    chk("var_rd_valid", 32'(rd_valid_b), 1);
    rd_ch_b = 2'd1;
    #1;
    chk("var_rd_other_valid", 32'(rd_valid_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
